// File: rtl/sccb_master_if.sv
// SCCB master bus bundle.
// Groups the request/response handshake with the camera sequencer and the
// SIO_C/SIO_D pad signals.
//   master modport : the SCCB master's view (drives req_ready, rsp_*, busy, sio_*)
//   slave  modport : the sequencer/pad side (drives req_*, sio_d_i)
interface sccb_master_if #(
  parameter int SUBADDR_BYTES = 1
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_rw;
  logic [6:0]                 req_id;
  logic [8*SUBADDR_BYTES-1:0] req_addr;
  logic [7:0]                 req_wdata;
  logic                       rsp_valid;
  logic [7:0]                 rsp_rdata;
  logic                       rsp_nack;
  logic                       busy;
  logic                       sio_c;
  logic                       sio_d_o;
  logic                       sio_d_oe;
  logic                       sio_d_i;

  modport master (
    input  req_valid, req_rw, req_id, req_addr, req_wdata, sio_d_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, busy,
           sio_c, sio_d_o, sio_d_oe
  );

  modport slave (
    output req_valid, req_rw, req_id, req_addr, req_wdata, sio_d_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, busy,
           sio_c, sio_d_o, sio_d_oe
  );
endinterface

// File: rtl/sccb_master.sv
// SCCB (OV7670-style) serial camera control bus master.
// Performs 3-phase register writes and 2-phase-write + 2-phase-read register
// reads. Every bit is four quarter periods of QUARTER_DIV clk cycles:
// Q0/Q1 with SIO_C low, Q2/Q3 with SIO_C high; SIO_D is sampled at Q2->Q3.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : sccb_master_if.master (request/response handshake + pads)
module sccb_master #(
  parameter int QUARTER_DIV   = 125,
  parameter int SUBADDR_BYTES = 1,
  parameter bit CHECK_ACK     = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  sccb_master_if.master bus
);

  localparam int DIV_W = $clog2(QUARTER_DIV);
  localparam int AW    = 8 * SUBADDR_BYTES;

  typedef enum logic [2:0] {IDLE, START, BYTE, XBIT, STOP, GAP} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       qtr;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic             phase_b;
  logic             rw_q;
  logic [6:0]       id_q;
  logic [AW-1:0]    addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rx_sr;
  logic             nack_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_rdata_q;
  logic             rsp_nack_q;

  logic             tick, phase_end, accept, rx_byte, last_byte;
  logic [1:0]       last_qtr, last_idx;
  logic [AW-1:0]    addr_sh;
  logic [7:0]       tx_byte;
  logic             sio_c_c, sio_d_c, sio_oe_c;

  assign tick      = (div_cnt == DIV_W'(QUARTER_DIV - 1));
  assign accept    = bus.req_valid && (state == IDLE);
  // In the second (read) phase, byte 1 is the one the slave sends.
  assign rx_byte   = phase_b && (byte_idx == 2'd1);
  assign last_idx  = phase_b ? 2'd1 :
                     (rw_q ? 2'(SUBADDR_BYTES) : 2'(SUBADDR_BYTES + 1));
  assign last_byte = (byte_idx == last_idx);
  assign phase_end = tick && (qtr == last_qtr);

  always_comb begin
    last_qtr = 2'd3;
    case (state)
      START:   last_qtr = 2'd1;
      STOP:    last_qtr = 2'd2;
      default: last_qtr = 2'd3;
    endcase
  end

  // Byte 0 is the device address with the R/W flag, then the sub-address
  // bytes MSB first, then the write data.
  always_comb begin
    addr_sh = (byte_idx == 2'd2) ? (addr_q << 8) : addr_q;
    tx_byte = wdata_q;
    if (byte_idx == 2'd0)
      tx_byte = {id_q, phase_b};
    else if (byte_idx <= 2'(SUBADDR_BYTES))
      tx_byte = addr_sh[AW-1 -: 8];
  end

  always_comb begin
    state_nxt = state;
    sio_c_c   = 1'b1;
    sio_d_c   = 1'b1;
    sio_oe_c  = 1'b1;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = START;
      START: begin
        sio_c_c = (qtr == 2'd0);
        sio_d_c = 1'b0;
        if (phase_end) state_nxt = BYTE;
      end
      BYTE: begin
        sio_c_c  = qtr[1];
        sio_d_c  = rx_byte | tx_byte[bit_idx];
        sio_oe_c = !rx_byte;
        if (phase_end && (bit_idx == 3'd0)) state_nxt = XBIT;
      end
      XBIT: begin
        // Released for the slave's don't-care bit; driven high as NA after a read byte.
        sio_c_c  = qtr[1];
        sio_oe_c = rx_byte;
        if (phase_end) state_nxt = last_byte ? STOP : BYTE;
      end
      STOP: begin
        sio_c_c = (qtr != 2'd0);
        sio_d_c = (qtr == 2'd2);
        if (phase_end) state_nxt = (rw_q && !phase_b) ? GAP : IDLE;
      end
      GAP: if (phase_end) state_nxt = START;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      qtr         <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      phase_b     <= 1'b0;
      rx_sr       <= '0;
      nack_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_nack_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        rw_q     <= bus.req_rw;
        id_q     <= bus.req_id;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        div_cnt  <= '0;
        qtr      <= '0;
        bit_idx  <= 3'd7;
        byte_idx <= '0;
        phase_b  <= 1'b0;
        nack_q   <= 1'b0;
      end else if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick) begin
          qtr <= phase_end ? 2'd0 : qtr + 2'd1;
          // Sample SIO_D in the middle of the SIO_C high time.
          if (state == BYTE && qtr == 2'd2 && rx_byte)
            rx_sr <= {rx_sr[6:0], bus.sio_d_i};
          if (CHECK_ACK && state == XBIT && qtr == 2'd2 && !rx_byte && bus.sio_d_i)
            nack_q <= 1'b1;
          if (phase_end) begin
            case (state)
              BYTE: if (bit_idx != 3'd0) bit_idx <= bit_idx - 3'd1;
              XBIT: begin
                bit_idx  <= 3'd7;
                byte_idx <= byte_idx + 2'd1;
              end
              STOP: begin
                if (rw_q && !phase_b) begin
                  phase_b  <= 1'b1;
                  byte_idx <= '0;
                end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_nack_q  <= nack_q;
                  if (rw_q) rsp_rdata_q <= rx_sr;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_nack  = rsp_nack_q;
  assign bus.sio_c     = sio_c_c;
  assign bus.sio_d_o   = sio_d_c;
  assign bus.sio_d_oe  = sio_oe_c;

endmodule

// File: tb/tb_sccb_master.sv
module tb_sccb_master;
  localparam int QD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   sel   = 1'b0;   // 0: instance A (1-byte sub-addr, ACK checked), 1: instance B (2-byte, unchecked)
  int   cyc = 0, n_checks = 0, n_fail = 0, n_acc = 0, n_rsp = 0;
  int   nack_byte = -1;
  logic [7:0] slv_rdata = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sccb_master_if #(.SUBADDR_BYTES(1)) ifa();
  sccb_master_if #(.SUBADDR_BYTES(2)) ifb();

  sccb_master #(.QUARTER_DIV(QD), .SUBADDR_BYTES(1), .CHECK_ACK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.master));
  sccb_master #(.QUARTER_DIV(QD), .SUBADDR_BYTES(2), .CHECK_ACK(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.master));

  // Shared bus model, attached to the selected master.
  logic m_c, m_do, m_oe, sda, slv_oe, slv_d;
  logic s_valid, s_ready, s_rw, s_rsp_valid, s_nack, s_busy;
  logic [6:0]  s_id;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata, s_rdata;

  always_comb begin
    m_c         = sel ? ifb.sio_c     : ifa.sio_c;
    m_do        = sel ? ifb.sio_d_o   : ifa.sio_d_o;
    m_oe        = sel ? ifb.sio_d_oe  : ifa.sio_d_oe;
    s_valid     = sel ? ifb.req_valid : ifa.req_valid;
    s_ready     = sel ? ifb.req_ready : ifa.req_ready;
    s_rw        = sel ? ifb.req_rw    : ifa.req_rw;
    s_id        = sel ? ifb.req_id    : ifa.req_id;
    s_addr      = sel ? ifb.req_addr  : {8'h00, ifa.req_addr};
    s_wdata     = sel ? ifb.req_wdata : ifa.req_wdata;
    s_rsp_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
    s_rdata     = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
    s_nack      = sel ? ifb.rsp_nack  : ifa.rsp_nack;
    s_busy      = sel ? ifb.busy      : ifa.busy;
  end

  assign sda         = m_oe ? m_do : (slv_oe ? slv_d : 1'b1);
  assign ifa.sio_d_i = sel ? 1'b1 : sda;
  assign ifb.sio_d_i = sel ? sda : 1'b1;

  typedef struct {
    bit         rw;
    logic [7:0] rdata;
    bit         nack;
    int         acc;
    int         lat;
  } exp_t;

  exp_t        exp_rsp[$];
  logic [11:0] exp_tok[$];   // 12'h400 START, 12'h800 STOP, else {x_bit, byte}
  logic [7:0]  last_rd[2];
  bit          acc_in_rsp = 1'b0;
  bit          prev_c = 1'b1, prev_d = 1'b1, is_read = 1'b0;
  logic [8:0]  sr = '0;
  int          bitcnt = 0, bytenum = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_token(input logic [11:0] got);
    check("bus_pending", exp_tok.size() != 0, 1);
    if (exp_tok.size() != 0) check("bus_tok", got, exp_tok.pop_front());
  endtask

  function automatic logic [11:0] tb_byte(input logic [7:0] b, input bit x);
    return {3'b000, x, b};
  endfunction

  task automatic push_expected();
    exp_t e;
    int sa;
    logic [15:0] t;
    sa      = sel ? 2 : 1;
    e.rw    = s_rw;
    e.rdata = slv_rdata;
    e.nack  = (sel == 1'b0) && (nack_byte >= 0);
    e.acc   = cyc + 1;
    e.lat   = QD * (s_rw ? ((2 + 36*(1+sa) + 3) + 4 + (2 + 72 + 3)) : (2 + 36*(2+sa) + 3));
    exp_rsp.push_back(e);
    exp_tok.push_back(12'h400);
    exp_tok.push_back(tb_byte({s_id, 1'b0}, nack_byte == 0));
    for (int k = 1; k <= sa; k++) begin
      t = s_addr >> (8 * (sa - k));
      exp_tok.push_back(tb_byte(t[7:0], nack_byte == k));
    end
    if (!s_rw) begin
      exp_tok.push_back(tb_byte(s_wdata, nack_byte == sa + 1));
      exp_tok.push_back(12'h800);
    end else begin
      exp_tok.push_back(12'h800);
      exp_tok.push_back(12'h400);
      exp_tok.push_back(tb_byte({s_id, 1'b1}, nack_byte == 0));
      exp_tok.push_back(tb_byte(slv_rdata, 1'b1));
      exp_tok.push_back(12'h800);
    end
  endtask

  always @(negedge clk) begin
    logic d;
    exp_t e;
    if (reset) begin
      exp_rsp.delete();
      exp_tok.delete();
      bitcnt = 0; bytenum = 0; is_read = 1'b0;
      slv_oe = 1'b0; slv_d = 1'b1;
      prev_c = 1'b1; prev_d = 1'b1;
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    end else begin
      d = sda;
      if (prev_c && m_c && prev_d && !d) begin
        bus_token(12'h400);
        bitcnt = 0; bytenum = 0; is_read = 1'b0; slv_oe = 1'b0;
      end else if (prev_c && m_c && !prev_d && d) begin
        bus_token(12'h800);
        slv_oe = 1'b0;
      end else if (!prev_c && m_c) begin
        sr = {sr[7:0], d};
        bitcnt++;
        if (bitcnt == 9) begin
          bus_token({3'b000, sr[0], sr[8:1]});
          if (bytenum == 0) is_read = sr[1];
          bytenum++;
          bitcnt = 0;
        end
      end else if (prev_c && !m_c) begin
        slv_oe = 1'b0;
        slv_d  = 1'b1;
        if (is_read && bytenum == 1 && bitcnt < 8) begin
          slv_oe = 1'b1;
          slv_d  = slv_rdata[7 - bitcnt];
        end else if (bitcnt == 8 && !(is_read && bytenum == 1)) begin
          slv_oe = (bytenum != nack_byte);
          slv_d  = 1'b0;
        end
      end
      prev_c = m_c;
      prev_d = d;

      if (s_rsp_valid) begin
        n_rsp++;
        check("rsp_pending", exp_rsp.size() != 0, 1);
        if (exp_rsp.size() != 0) begin
          e = exp_rsp.pop_front();
          check("latency", cyc - e.acc, e.lat);
          check("rsp_nack", s_nack, e.nack);
          check("rsp_rdata", s_rdata, e.rw ? e.rdata : last_rd[sel]);
          if (e.rw) last_rd[sel] = e.rdata;
          check("bus_tok_left", exp_tok.size(), 0);
        end
      end

      if (s_valid && s_ready) begin
        acc_in_rsp = s_rsp_valid;
        n_acc++;
        push_expected();
      end
    end
  end

  task automatic drive(input bit rw, input logic [6:0] id, input logic [15:0] addr,
                       input logic [7:0] wd, input bit v);
    if (!sel) begin
      ifa.req_valid = v; ifa.req_rw = rw; ifa.req_id = id;
      ifa.req_addr = addr[7:0]; ifa.req_wdata = wd;
    end else begin
      ifb.req_valid = v; ifb.req_rw = rw; ifb.req_id = id;
      ifb.req_addr = addr; ifb.req_wdata = wd;
    end
  endtask

  task automatic send(input bit rw, input logic [6:0] id, input logic [15:0] addr, input logic [7:0] wd);
    int n0;
    n0 = n_acc;
    drive(rw, id, addr, wd, 1'b1);
    for (int i = 0; i < 50 && n_acc == n0; i++) @(posedge clk);
    #1;
    drive(rw, id, addr, wd, 1'b0);
    check("accepted", n_acc - n0, 1);
  endtask

  task automatic finish_tx();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (exp_rsp.size() == 0 && !s_busy) break;
    end
    check("tx_done", exp_rsp.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    ifa.req_valid = 1'b1; ifa.req_rw = 1'b0; ifa.req_id = 7'h21; ifa.req_addr = 8'h00; ifa.req_wdata = 8'h00;
    ifb.req_valid = 1'b0; ifb.req_rw = 1'b0; ifb.req_id = 7'h21; ifb.req_addr = 16'h0; ifb.req_wdata = 8'h00;
    reset = 1'b1;

    // Reset with a pending request.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_ready", ifa.req_ready, 1);
      check("rst_busy", ifa.busy, 0);
      check("rst_rsp_valid", ifa.rsp_valid, 0);
      check("rst_sio_c", ifa.sio_c, 1);
      check("rst_sio_d_o", ifa.sio_d_o, 1);
      check("rst_sio_d_oe", ifa.sio_d_oe, 1);
    end
    check("rst_rdata", ifa.rsp_rdata, 8'h00);
    check("rst_nack", ifa.rsp_nack, 0);
    ifa.req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("no_accept_in_reset", ifa.busy, 0);

    // Instance A: write, read, NACK, clean write.
    send(1'b0, 7'h21, 16'h0012, 8'h80);
    @(posedge clk); #1;
    check("busy_after_accept", ifa.busy, 1);
    finish_tx();
    slv_rdata = 8'h76;
    send(1'b1, 7'h21, 16'h000A, 8'h00);
    finish_tx();
    nack_byte = 1;
    send(1'b0, 7'h21, 16'h0055, 8'hAA);
    finish_tx();
    nack_byte = -1;
    send(1'b0, 7'h21, 16'h003C, 8'hC3);
    finish_tx();

    // Reset during bit 3 of the sub-address byte.
    send(1'b0, 7'h21, 16'h0012, 8'hA5);
    for (int i = 0; i < 500 && !(bytenum == 1 && bitcnt == 4); i++) begin
      @(posedge clk); #1;
    end
    check("reached_subaddr_bit3", bytenum * 16 + bitcnt, 20);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_sio_c", ifa.sio_c, 1);
    check("mid_rst_sio_d_o", ifa.sio_d_o, 1);
    check("mid_rst_sio_d_oe", ifa.sio_d_oe, 1);
    check("mid_rst_busy", ifa.busy, 0);
    check("mid_rst_ready", ifa.req_ready, 1);
    check("mid_rst_rsp_valid", ifa.rsp_valid, 0);
    reset = 1'b0;
    n0 = n_rsp;
    repeat (600) @(posedge clk);
    #1;
    check("no_rsp_after_reset", n_rsp - n0, 0);
    send(1'b0, 7'h21, 16'h0012, 8'hA5);
    finish_tx();

    // Instance B: two-byte sub-address, request held valid with new fields.
    sel = 1'b1;
    slv_rdata = 8'h9C;
    n0 = n_acc;
    drive(1'b0, 7'h21, 16'h1234, 8'h5A, 1'b1);
    for (int i = 0; i < 50 && n_acc == n0; i++) @(posedge clk);
    #1;
    drive(1'b1, 7'h21, 16'h0102, 8'hEE, 1'b1);
    for (int i = 0; i < 1000 && n_acc < n0 + 2; i++) @(posedge clk);
    #1;
    drive(1'b1, 7'h21, 16'h0102, 8'hEE, 1'b0);
    check("b2b_count", n_acc - n0, 2);
    check("b2b_in_rsp_cycle", acc_in_rsp, 1);
    finish_tx();

    // Instance B ignores a released X bit.
    nack_byte = 2;
    send(1'b0, 7'h21, 16'hABCD, 8'h3C);
    finish_tx();
    nack_byte = -1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
